// File: rtl/turfio_cout_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : turfio_cout_sched
// Description : Command-slot scheduler for turfio_cout. Holds the link in
//               training until released and exits training on a sync
//               boundary. Once running, it arbitrates the per-cycle command
//               slot: trigger has strict priority with a starvation limit,
//               and run-control and register-access share the remaining
//               slots round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module turfio_cout_sched #(
  parameter int unsigned MAX_TRIG_RUN = 8,
  parameter int unsigned TRAIN_MIN    = 64,
  parameter logic [31:0] IDLE_WORD    = 32'h0
) (
  input  logic        if_clk_i,
  input  logic        if_rstb_i,
  input  logic        train_req_i,
  input  logic        sync_i,
  input  logic [31:0] trig_cmd_i,
  input  logic        trig_valid_i,
  output logic        trig_ready_o,
  input  logic [31:0] rc_cmd_i,
  input  logic        rc_valid_i,
  output logic        rc_ready_o,
  input  logic [31:0] reg_cmd_i,
  input  logic        reg_valid_i,
  output logic        reg_ready_o,
  output logic [31:0] cout_command_o,
  output logic        cout_train_o,
  output logic        running_o,
  output logic [15:0] cmd_count_o
);

  localparam logic [1:0]  ST_TRAIN  = 2'd0;
  localparam logic [1:0]  ST_ARM    = 2'd1;
  localparam logic [1:0]  ST_RUN    = 2'd2;
  localparam logic [15:0] TRAIN_SAT = 16'(TRAIN_MIN);
  localparam logic [7:0]  TRIG_MAX  = 8'(MAX_TRIG_RUN);

  logic [1:0]  state_q, state_d;
  logic [15:0] train_cnt_q, train_cnt_d;
  logic [7:0]  trig_run_q, trig_run_d;
  logic        rr_ptr_q, rr_ptr_d;        // 0: rc next, 1: reg next
  logic [31:0] cmd_q, cmd_d;
  logic [15:0] cmd_count_q, cmd_count_d;

  logic grant_trig, grant_rc, grant_reg;
  logic ctl_pending, trig_blocked, any_grant;

  assign ctl_pending  = rc_valid_i | reg_valid_i;
  assign trig_blocked = (trig_run_q == TRIG_MAX) && ctl_pending;
  assign any_grant    = grant_trig | grant_rc | grant_reg;

  // State register: training/arm/run sequencing
  always_ff @(posedge if_clk_i or negedge if_rstb_i) begin
    if (!if_rstb_i) state_q <= ST_TRAIN;
    else            state_q <= state_d;
  end

  // Next-state logic: release from training waits for the sync boundary
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_TRAIN: if (train_cnt_q == TRAIN_SAT && !train_req_i) state_d = ST_ARM;
      ST_ARM: begin
        if (train_req_i) state_d = ST_TRAIN;
        else if (sync_i) state_d = ST_RUN;
      end
      ST_RUN:   if (train_req_i) state_d = ST_TRAIN;
      default:  state_d = ST_TRAIN;
    endcase
  end

  // Output logic: one grant per cycle, trigger first unless it has hit its run limit
  always_comb begin
    grant_trig = 1'b0;
    grant_rc   = 1'b0;
    grant_reg  = 1'b0;
    if (state_q == ST_RUN && !train_req_i) begin
      if (trig_valid_i && !trig_blocked) begin
        grant_trig = 1'b1;
      end else if (rc_valid_i && reg_valid_i) begin
        if (rr_ptr_q) grant_reg = 1'b1;
        else          grant_rc  = 1'b1;
      end else if (rc_valid_i) begin
        grant_rc = 1'b1;
      end else if (reg_valid_i) begin
        grant_reg = 1'b1;
      end
    end
  end

  // Datapath next values: counters, round-robin pointer and issued word
  always_comb begin
    train_cnt_d = train_cnt_q;
    case (state_q)
      ST_TRAIN: if (train_cnt_q < TRAIN_SAT) train_cnt_d = train_cnt_q + 16'd1;
      ST_RUN:   if (train_req_i) train_cnt_d = 16'd0;
      default:  train_cnt_d = train_cnt_q;
    endcase

    trig_run_d = trig_run_q;
    if (grant_rc || grant_reg || !ctl_pending) trig_run_d = 8'd0;
    else if (grant_trig)                       trig_run_d = trig_run_q + 8'd1;

    rr_ptr_d = rr_ptr_q;
    if (grant_rc)       rr_ptr_d = 1'b1;
    else if (grant_reg) rr_ptr_d = 1'b0;

    cmd_d = IDLE_WORD;
    if (grant_trig)     cmd_d = trig_cmd_i;
    else if (grant_rc)  cmd_d = rc_cmd_i;
    else if (grant_reg) cmd_d = reg_cmd_i;

    cmd_count_d = cmd_count_q + {15'd0, any_grant};
  end

  // Datapath registers
  always_ff @(posedge if_clk_i or negedge if_rstb_i) begin
    if (!if_rstb_i) begin
      train_cnt_q <= 16'd0;
      trig_run_q  <= 8'd0;
      rr_ptr_q    <= 1'b0;
      cmd_q       <= IDLE_WORD;
      cmd_count_q <= 16'd0;
    end else begin
      train_cnt_q <= train_cnt_d;
      trig_run_q  <= trig_run_d;
      rr_ptr_q    <= rr_ptr_d;
      cmd_q       <= cmd_d;
      cmd_count_q <= cmd_count_d;
    end
  end

  assign trig_ready_o   = grant_trig;
  assign rc_ready_o     = grant_rc;
  assign reg_ready_o    = grant_reg;
  assign cout_command_o = cmd_q;
  assign cout_train_o   = (state_q != ST_RUN);
  assign running_o      = (state_q == ST_RUN);
  assign cmd_count_o    = cmd_count_q;

endmodule
`default_nettype wire

// File: tb/tb_turfio_cout_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_turfio_cout_sched
// Description : Directed self-checking bench for turfio_cout_sched with a
//               scoreboard queue of expected command words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_turfio_cout_sched;

  localparam logic [31:0] IDLE    = 32'h0;
  localparam logic [31:0] TRIG_W  = 32'h0001_0000;
  localparam logic [31:0] RC_W    = 32'h0002_0000;
  localparam logic [31:0] REG_W   = 32'h0003_0000;

  logic        clk = 1'b0;
  logic        rstb;
  logic        train_req, sync;
  logic [31:0] trig_cmd, rc_cmd, reg_cmd;
  logic        trig_valid, rc_valid, reg_valid;
  logic        trig_ready, rc_ready, reg_ready;
  logic [31:0] cout_command;
  logic        cout_train, running;
  logic [15:0] cmd_count;

  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] sb_q[$];
  logic [15:0] exp_count;
  int          edges;

  always #5 clk = ~clk;

  turfio_cout_sched #(
    .MAX_TRIG_RUN(8),
    .TRAIN_MIN   (64),
    .IDLE_WORD   (32'h0)
  ) dut (
    .if_clk_i      (clk),
    .if_rstb_i     (rstb),
    .train_req_i   (train_req),
    .sync_i        (sync),
    .trig_cmd_i    (trig_cmd),
    .trig_valid_i  (trig_valid),
    .trig_ready_o  (trig_ready),
    .rc_cmd_i      (rc_cmd),
    .rc_valid_i    (rc_valid),
    .rc_ready_o    (rc_ready),
    .reg_cmd_i     (reg_cmd),
    .reg_valid_i   (reg_valid),
    .reg_ready_o   (reg_ready),
    .cout_command_o(cout_command),
    .cout_train_o  (cout_train),
    .running_o     (running),
    .cmd_count_o   (cmd_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One RUN cycle: check combinational readies, queue the expected word, then
  // compare the registered word and running count one edge later.
  task automatic run_cycle(input logic [2:0] exp_rdy, input logic [31:0] exp_word);
    logic [31:0] w;
    #1;
    chk("trig_ready", {31'd0, trig_ready}, {31'd0, exp_rdy[2]});
    chk("rc_ready",   {31'd0, rc_ready},   {31'd0, exp_rdy[1]});
    chk("reg_ready",  {31'd0, reg_ready},  {31'd0, exp_rdy[0]});
    sb_q.push_back(exp_word);
    if (exp_rdy != 3'b000) exp_count = exp_count + 16'd1;
    tick();
    w = sb_q.pop_front();
    chk("cout_command", cout_command, w);
    chk("cmd_count", {16'd0, cmd_count}, {16'd0, exp_count});
  endtask

  // Drive sync every 8 cycles until the link is running; no grants allowed before.
  task automatic train_to_run(output int n_edges);
    n_edges = 0;
    for (int n = 0; n < 300; n++) begin
      sync = ((n % 8) == 7);
      #1;
      if (!running) chk("ready_while_training", {29'd0, trig_ready, rc_ready, reg_ready}, 32'd0);
      tick();
      n_edges = n + 1;
      if (running) break;
    end
    sync = 1'b0;
    if (!running) chk("train_timeout", {31'd0, running}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstb = 1'b0; train_req = 1'b0; sync = 1'b0;
    trig_cmd = TRIG_W; rc_cmd = RC_W; reg_cmd = REG_W;
    trig_valid = 1'b0; rc_valid = 1'b0; reg_valid = 1'b0;
    exp_count = 16'd0;

    // Reset values
    #12;
    chk("rst_train",   {31'd0, cout_train}, 32'd1);
    chk("rst_running", {31'd0, running},    32'd0);
    chk("rst_command", cout_command,        IDLE);
    chk("rst_count",   {16'd0, cmd_count},  32'd0);
    chk("rst_ready",   {29'd0, trig_ready, rc_ready, reg_ready}, 32'd0);
    @(negedge clk);
    rstb = 1'b1;

    // Training: counter saturates at edge 64, ARM at 65, first sync after that at edge 72
    train_to_run(edges);
    chk("train_exit_edge", edges, 32'd72);
    chk("train_fell",      {31'd0, cout_train}, 32'd0);
    chk("running_rose",    {31'd0, running},    32'd1);
    chk("run_cmd_idle",    cout_command,        IDLE);

    // rc/reg round-robin, starting with rc
    rc_valid = 1'b1; reg_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) run_cycle(3'b010, RC_W);
      else            run_cycle(3'b001, REG_W);
    end
    rc_valid = 1'b0; reg_valid = 1'b0;
    run_cycle(3'b000, IDLE);

    // Trigger alone is never throttled
    trig_valid = 1'b1;
    for (int i = 0; i < 10; i++) run_cycle(3'b100, TRIG_W);

    // Trigger with rc pending: 8 trigger grants then one rc grant, repeating
    rc_valid = 1'b1;
    for (int i = 0; i < 27; i++) begin
      if (i % 9 < 8) run_cycle(3'b100, TRIG_W);
      else           run_cycle(3'b010, RC_W);
    end
    trig_valid = 1'b0; rc_valid = 1'b0;
    run_cycle(3'b000, IDLE);

    // Training request mid-RUN with rc pending: no grant, back to training
    rc_valid = 1'b1; train_req = 1'b1;
    run_cycle(3'b000, IDLE);
    chk("retrain_train",   {31'd0, cout_train}, 32'd1);
    chk("retrain_running", {31'd0, running},    32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("retrain_rc_ready", {31'd0, rc_ready}, 32'd0);
    end
    train_req = 1'b0;
    train_to_run(edges);
    run_cycle(3'b010, RC_W);

    // Asynchronous reset in the middle of a grant
    #1;
    chk("pre_reset_rc_ready", {31'd0, rc_ready}, 32'd1);
    rstb = 1'b0;
    #1;
    chk("arst_ready",   {29'd0, trig_ready, rc_ready, reg_ready}, 32'd0);
    chk("arst_train",   {31'd0, cout_train}, 32'd1);
    chk("arst_running", {31'd0, running},    32'd0);
    chk("arst_command", cout_command,        IDLE);
    chk("arst_count",   {16'd0, cmd_count},  32'd0);
    @(negedge clk);
    rstb = 1'b1;
    exp_count = 16'd0;
    tick();
    chk("post_rst_train", {31'd0, cout_train}, 32'd1);
    chk("post_rst_count", {16'd0, cmd_count},  32'd0);

    // Counter wrap: 65535 rc grants, then one more
    train_to_run(edges);
    chk("wrap_start_count", {16'd0, cmd_count}, 32'd0);
    repeat (65535) @(posedge clk);
    #1;
    chk("wrap_full_count", {16'd0, cmd_count}, 32'h0000_FFFF);
    exp_count = 16'hFFFF;
    run_cycle(3'b010, RC_W);
    chk("wrap_zero_count", {16'd0, cmd_count}, 32'd0);
    rc_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
